register_dump_tx: RTL and testbench
===================================

Name: register_dump_tx

Overview:
- Reads the register-file debug outputs and streams a frame over the UART transmitter's byte interface.
- The register file exposes its 32 registers as 32-bit debug outputs; this block is the consumer of that interface.
- On a start pulse it snapshots all registers, then sends a header byte followed by every register, one byte at a time.
- It sits between the register-file debug outputs and the UART TX byte interface in the debug path.

Parameters:
- NUM_REGS, 32, number of registers in the dump; the flat bus width is 32*NUM_REGS.
- HEADER_BYTE, 8'hA5, frame-start byte sent before the register data.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- registers_flat  input  32*NUM_REGS  register k occupies bits [32k+31:32k].
- tx_busy  input  1  UART transmitter is shifting a byte.
- tx_done  input  1  one-cycle pulse when the UART finishes a byte.
- tx_data  output  8  byte presented to the UART.
- tx_start  output  1  one-cycle strobe that launches tx_data.
- dump_busy  output  1  high from snapshot until DONE is exited.
- dump_done  output  1  one-cycle pulse at the end of the frame.
- byte_count  output  8  bytes launched so far in the current frame.

Behaviour:
- Reset (asynchronous, active-low; takes effect immediately, including mid-frame):
  - state goes to IDLE.
  - tx_data=0, tx_start=0, dump_busy=0, dump_done=0, byte_count=0.
  - the snapshot is cleared to 0.
- States: IDLE, SEND, WAIT, DONE.
- IDLE:
  - if start=1 at edge N, the snapshot register captures registers_flat at edge N, and byte index and byte_count are set to 0.
  - the next state is SEND and dump_busy=1 from edge N.
- SEND:
  - if tx_busy=0, tx_start=1 for exactly one cycle with tx_data equal to the current byte; byte_count increments at the same edge; the next state is WAIT.
  - if tx_busy=1, the block stays in SEND with tx_start=0.
  - tx_done is ignored in SEND.
- WAIT:
  - tx_start=0 and tx_data holds its value.
  - on tx_done=1: if the byte just sent was the last one, go to DONE; otherwise advance the byte index and go to SEND.
- DONE: dump_done=1 for one cycle, dump_busy=0 at the following edge, then return to IDLE.
- Byte order:
  - index 0 is HEADER_BYTE.
  - index 1+4k+j is byte j of snapshot register k, with j=0 being bits [31:24] (most-significant first).
  - registers go in ascending k.
  - total frame length is 1+4*NUM_REGS bytes (129 at the default).
- Snapshot: registers_flat changes after the capture edge do not affect the frame.
- start while dump_busy=1, or in DONE, is ignored; it is not queued.
- byte_count saturates at 8'hFF; it is never exceeded at the default parameters. It holds its final value in IDLE until the next start.
- Minimum spacing between tx_start pulses: 2 cycles (SEND→WAIT→SEND), given an immediate tx_done.
- tx_done and start are both sampled per edge; a tx_done arriving in any state other than WAIT is dropped.
- Implementation: the byte mux reads the snapshot by index; a combinational 1024-bit shift of registers_flat is not allowed.

Test Plan:
- Reset: hold reset_n=0 with start=1 -> all outputs 0 and no tx_start. Release reset -> IDLE, nothing happens until a fresh start.
- Full dump: reg0=32'h11223344, reg31=32'hDEADBEEF, regk=k otherwise; UART model returns tx_done 10 cycles after tx_start -> bytes are A5,11,22,33,44,00,00,00,01,...,DE,AD,BE,EF. Expect exactly 129 tx_start pulses, then dump_done one cycle after the 129th tx_done, and byte_count=129.
- Snapshot: after start, write reg0=32'hFFFFFFFF and then write every register -> the frame still carries the originally captured values.
- Flow control: hold tx_busy=1 for 20 cycles in SEND -> tx_start stays low and fires on the first cycle tx_busy=0. A start pulse mid-frame and a spurious tx_done in SEND -> no change to the sequence.
- Reset mid-frame: assert reset_n=0 after byte 50 -> tx_start/dump_busy drop immediately. A new start -> the frame restarts from HEADER_BYTE with byte_count=1 after the first byte.
- Back-to-back: pulse start in the IDLE cycle right after dump_done -> a second full 129-byte frame with a fresh snapshot.

Source files
------------

// File: rtl/register_dump_tx_if.sv
// Byte-level handshake between the register dump streamer and the UART transmitter.
// The master launches bytes; the slave (UART) reports busy/done.
interface register_dump_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;

  modport master (output tx_data, output tx_start, input tx_busy, input tx_done);
  modport slave  (input tx_data, input tx_start, output tx_busy, output tx_done);
endinterface

// File: rtl/register_dump_tx.sv
// Snapshots the register-file debug bus on start and streams a header byte followed by
// every register (MSB first, ascending index) over the UART byte interface.
module register_dump_tx #(
  parameter int         NUM_REGS    = 32,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [32*NUM_REGS-1:0]    registers_flat,
  register_dump_tx_if.master        uart,
  output logic                      dump_busy,
  output logic                      dump_done,
  output logic [7:0]                byte_count
);

  localparam int LAST_IDX = 4 * NUM_REGS;
  localparam int IDX_W    = $clog2(LAST_IDX + 1);
  localparam int REG_W    = $clog2(NUM_REGS);
  localparam int OFF_W    = $clog2(32 * NUM_REGS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]            state_r;
  logic [32*NUM_REGS-1:0] snap_r;
  logic [IDX_W-1:0]      idx_r;
  logic [7:0]            tx_data_r;
  logic                  tx_start_r;
  logic                  dump_busy_r;
  logic                  dump_done_r;
  logic [7:0]            byte_count_r;

  logic [OFF_W-1:0]      bit_off_s;
  logic [7:0]            cur_byte_s;
  logic                  last_s;

  // Frame index 1+4k+j maps to register k, byte j counted from the MSB; the
  // low two index bits are inverted so j=0 lands on bits [31:24].
  function automatic logic [OFF_W-1:0] byte_offset(input logic [IDX_W-1:0] idx);
    logic [REG_W+1:0] m;
    m = idx[REG_W+1:0] - {{(REG_W+1){1'b0}}, 1'b1};
    return {m[REG_W+1:2], ~m[1:0], 3'b000};
  endfunction

  assign last_s = (idx_r == LAST_IDX[IDX_W-1:0]);

  // Byte mux: header at index 0, otherwise one byte of the captured snapshot.
  always_comb begin
    bit_off_s  = {OFF_W{1'b0}};
    cur_byte_s = HEADER_BYTE;
    if (idx_r == {IDX_W{1'b0}}) begin
      cur_byte_s = HEADER_BYTE;
    end else begin
      bit_off_s  = byte_offset(idx_r);
      cur_byte_s = snap_r[bit_off_s +: 8];
    end
  end

  // Frame sequencer: snapshot, launch each byte, wait for UART completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      snap_r       <= {(32*NUM_REGS){1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      tx_data_r    <= 8'h00;
      tx_start_r   <= 1'b0;
      dump_busy_r  <= 1'b0;
      dump_done_r  <= 1'b0;
      byte_count_r <= 8'h00;
    end else begin
      tx_start_r  <= 1'b0;
      dump_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            snap_r       <= registers_flat;
            idx_r        <= {IDX_W{1'b0}};
            byte_count_r <= 8'h00;
            dump_busy_r  <= 1'b1;
            state_r      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!uart.tx_busy) begin
            tx_start_r <= 1'b1;
            tx_data_r  <= cur_byte_s;
            if (byte_count_r != 8'hFF) begin
              byte_count_r <= byte_count_r + 8'd1;
            end
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (uart.tx_done) begin
            if (last_s) begin
              dump_done_r <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
              state_r <= ST_SEND;
            end
          end
        end
        ST_DONE: begin
          dump_busy_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign uart.tx_data  = tx_data_r;
  assign uart.tx_start = tx_start_r;
  assign dump_busy     = dump_busy_r;
  assign dump_done     = dump_done_r;
  assign byte_count    = byte_count_r;

endmodule

// File: tb/tb_register_dump_tx.sv
// Scoreboard bench for register_dump_tx: expected frame bytes are queued at each start
// and popped by an independent monitor on every tx_start strobe.
module tb_register_dump_tx;

  localparam int NUM_REGS  = 32;
  localparam int FRAME_LEN = 1 + 4 * NUM_REGS;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic                   start;
  logic [32*NUM_REGS-1:0] registers_flat;
  logic                   dump_busy;
  logic                   dump_done;
  logic [7:0]             byte_count;
  logic [31:0]            regs_tb [NUM_REGS];

  logic model_busy, model_done, busy_force, spur_done;
  logic hold_req = 1'b0;
  logic last_done_edge = 1'b0;

  logic [7:0] exp_q [$];
  int n_cmp = 0;
  int n_fail = 0;
  int tx_count = 0;

  register_dump_tx_if uart();

  assign uart.tx_busy = model_busy | busy_force;
  assign uart.tx_done = model_done | spur_done;

  register_dump_tx #(.NUM_REGS(NUM_REGS), .HEADER_BYTE(8'hA5)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .registers_flat (registers_flat),
    .uart           (uart),
    .dump_busy      (dump_busy),
    .dump_done      (dump_done),
    .byte_count     (byte_count)
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) registers_flat[k*32 +: 32] = regs_tb[k];
  end

  always @(posedge clock) last_done_edge <= uart.tx_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every launched byte is compared against the head of the scoreboard.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && uart.tx_start === 1'b1) begin
      tx_count = tx_count + 1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL tx_data: got %0h with empty scoreboard (t=%0t)", uart.tx_data, $time);
      end else begin
        check("tx_data", {24'h0, uart.tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic serve_byte();
    logic hold;
    hold = 1'b0;
    model_busy = 1'b1;
    repeat (9) @(negedge clock);
    model_busy = 1'b0;
    model_done = 1'b1;
    if (hold_req) begin
      hold_req   = 1'b0;
      busy_force = 1'b1;
      hold       = 1'b1;
    end
    @(negedge clock);
    model_done = 1'b0;
    if (hold) begin
      for (int i = 0; i < 20; i++) begin
        check("tx_start held off while busy", {31'h0, uart.tx_start}, 32'h0);
        if (i == 5) spur_done = 1'b1;
        if (i == 6) spur_done = 1'b0;
        @(negedge clock);
      end
      busy_force = 1'b0;
      @(negedge clock);
      check("tx_start on first free cycle", {31'h0, uart.tx_start}, 32'h1);
      if (uart.tx_start === 1'b1) serve_byte();
    end
  endtask

  // UART model: tx_done arrives 10 cycles after each tx_start.
  initial begin
    model_busy = 1'b0;
    model_done = 1'b0;
    busy_force = 1'b0;
    spur_done  = 1'b0;
    forever begin
      @(negedge clock);
      if (uart.tx_start === 1'b1 && reset_n === 1'b1) serve_byte();
    end
  end

  task automatic push_frame();
    exp_q.push_back(8'hA5);
    for (int k = 0; k < NUM_REGS; k++)
      for (int j = 0; j < 4; j++) exp_q.push_back(regs_tb[k][31-8*j -: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_count(input int base, input int n, input int budget, input string what);
    int c = 0;
    while ((tx_count - base) < n && c < budget) begin
      @(negedge clock);
      #1;
      c++;
    end
    check(what, 32'(tx_count - base), 32'(n));
  endtask

  task automatic wait_done(input int base, input int budget);
    int c = 0;
    while (dump_done !== 1'b1 && c < budget) begin
      @(negedge clock);
      #1;
      c++;
    end
    check("dump_done seen", {31'h0, dump_done}, 32'h1);
    check("frame tx_start count", 32'(tx_count - base), 32'(FRAME_LEN));
    check("byte_count at end", {24'h0, byte_count}, 32'd129);
    check("tx_done one cycle before dump_done", {31'h0, last_done_edge}, 32'h1);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    @(negedge clock);
    check("dump_done one cycle", {31'h0, dump_done}, 32'h0);
    check("dump_busy low after DONE", {31'h0, dump_busy}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset_n = 1'b0;
    start   = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) regs_tb[k] = 32'h0;
    repeat (3) @(negedge clock);
    check("reset tx_start", {31'h0, uart.tx_start}, 32'h0);
    check("reset tx_data", {24'h0, uart.tx_data}, 32'h0);
    check("reset dump_busy", {31'h0, dump_busy}, 32'h0);
    check("reset dump_done", {31'h0, dump_done}, 32'h0);
    check("reset byte_count", {24'h0, byte_count}, 32'h0);
    start   = 1'b0;
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("idle without start: tx_start count", 32'(tx_count), 32'h0);
    check("idle without start: dump_busy", {31'h0, dump_busy}, 32'h0);

    // Frame 1: full dump with the reference pattern.
    for (int k = 0; k < NUM_REGS; k++) regs_tb[k] = 32'(k);
    regs_tb[0]  = 32'h11223344;
    regs_tb[31] = 32'hDEADBEEF;
    base = tx_count;
    push_frame();
    pulse_start();
    check("dump_busy after start", {31'h0, dump_busy}, 32'h1);
    wait_done(base, 3000);

    // Frame 2: snapshot isolation, flow control, spurious tx_done and a mid-frame start.
    repeat (3) @(negedge clock);
    for (int k = 0; k < NUM_REGS; k++) regs_tb[k] = {8'(k), 8'hC3, 8'(255 - k), 8'h5A};
    base = tx_count;
    push_frame();
    pulse_start();
    regs_tb[0] = 32'hFFFFFFFF;
    @(negedge clock);
    for (int k = 0; k < NUM_REGS; k++) regs_tb[k] = ~regs_tb[k];
    wait_count(base, 30, 1000, "reach byte 30");
    hold_req = 1'b1;
    wait_count(base, 60, 1000, "reach byte 60");
    pulse_start();
    check("dump_busy through mid-frame start", {31'h0, dump_busy}, 32'h1);
    wait_done(base, 3000);

    // Frame 3: reset in the middle of the frame, then a clean restart.
    repeat (3) @(negedge clock);
    base = tx_count;
    push_frame();
    pulse_start();
    wait_count(base, 50, 1000, "reach byte 50");
    reset_n = 1'b0;
    #1;
    check("tx_start drops on reset", {31'h0, uart.tx_start}, 32'h0);
    check("dump_busy drops on reset", {31'h0, dump_busy}, 32'h0);
    check("byte_count cleared on reset", {24'h0, byte_count}, 32'h0);
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (25) @(negedge clock);
    check("idle after reset release", {31'h0, dump_busy}, 32'h0);
    base = tx_count;
    push_frame();
    pulse_start();
    wait_count(base, 1, 50, "first byte after restart");
    check("restart header byte", {24'h0, uart.tx_data}, 32'h000000A5);
    check("byte_count after first byte", {24'h0, byte_count}, 32'h1);
    wait_done(base, 3000);

    // Frame 4: start in the IDLE cycle immediately after dump_done, fresh snapshot.
    check("byte_count held in IDLE", {24'h0, byte_count}, 32'd129);
    for (int k = 0; k < NUM_REGS; k++) regs_tb[k] = 32'h01010101 * 32'(k + 3);
    base = tx_count;
    push_frame();
    pulse_start();
    check("back-to-back dump_busy", {31'h0, dump_busy}, 32'h1);
    wait_done(base, 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
